// File: rtl/xgmii_pkg.sv
// Shared XGMII character constants, fixed control words and the TX state encoding.
package xgmii_pkg;

    localparam logic [7:0] IDLE  = 8'h07;
    localparam logic [7:0] START = 8'hFB;
    localparam logic [7:0] TERM  = 8'hFD;
    localparam logic [7:0] ERROR = 8'hFE;

    localparam logic [71:0] IDLE_WORD  = 72'hff_0707070707070707;
    localparam logic [71:0] ERROR_WORD = 72'hff_fefefefefefefefe;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StDrain,
        StGap
    } tx_state_e;

endpackage

// File: rtl/xgmii_term_detect.sv
// Flags a 72-bit XGMII word carrying a terminate character in any control lane.
module xgmii_term_detect
    import xgmii_pkg::*;
(
    input  logic [71:0] word,
    output logic        is_term
);

    always_comb begin
        is_term = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (word[64+i] && (word[8*i +: 8] == TERM)) begin
                is_term = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo72toxgmii.sv
// Reads frame words from an FWFT FIFO and drives the XGMII TX bus with idle gap and underrun abort.
// Optional frame/underrun counters are enabled by defining FIFO72TOXGMII_STATS_EN.
module fifo72toxgmii
    import xgmii_pkg::*;
#(
    parameter logic [3:0] Gap = 4'h2
) (
    input  logic        sys_rst,
    input  logic        xgmii_tx_clk,
    input  logic [71:0] dout,
    input  logic        empty,
    output logic        rd_en,
    output logic        rd_clk,
    output logic [71:0] xgmii_txd
`ifdef FIFO72TOXGMII_STATS_EN
    ,
    output logic [31:0] tx_frames,
    output logic [15:0] tx_underruns
`endif
);

    // A zero gap lets the next start follow a frame end with no GAP cycles at all.
    localparam tx_state_e AfterEnd = (Gap == 4'd0) ? StIdle : StGap;

    tx_state_e  state;
    logic [3:0] gap_cnt;
    logic       is_start;
    logic       is_term;

    assign rd_clk   = xgmii_tx_clk;
    assign is_start = dout[64] && (dout[7:0] == START);

    xgmii_term_detect u_term_detect (
        .word    (dout),
        .is_term (is_term)
    );

    always_comb begin
        rd_en = 1'b0;
        unique case (state)
            StIdle, StData: rd_en = !empty;
            StDrain:        rd_en = !empty && !is_start;
            default:        rd_en = 1'b0;
        endcase
    end

    always_ff @(posedge xgmii_tx_clk) begin
        if (sys_rst) begin
            state     <= StIdle;
            gap_cnt   <= 4'd0;
            xgmii_txd <= IDLE_WORD;
        end else begin
            unique case (state)
                StIdle: begin
                    xgmii_txd <= IDLE_WORD;
                    if (!empty && is_start) begin
                        xgmii_txd <= dout;
                        if (is_term) begin
                            state   <= AfterEnd;
                            gap_cnt <= Gap;
                        end else begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (!empty) begin
                        xgmii_txd <= dout;
                        if (is_term) begin
                            state   <= AfterEnd;
                            gap_cnt <= Gap;
                        end
                    end else begin
                        xgmii_txd <= ERROR_WORD;
                        state     <= StDrain;
                    end
                end
                StDrain: begin
                    xgmii_txd <= IDLE_WORD;
                    // A waiting start is left in the FIFO so the new frame begins cleanly.
                    if (!empty && (is_start || is_term)) begin
                        state   <= AfterEnd;
                        gap_cnt <= Gap;
                    end
                end
                StGap: begin
                    xgmii_txd <= IDLE_WORD;
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                    if (gap_cnt <= 4'd1) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    xgmii_txd <= IDLE_WORD;
                end
            endcase
        end
    end

`ifdef FIFO72TOXGMII_STATS_EN
    logic frame_sent;
    logic error_sent;

    assign frame_sent = rd_en && is_term &&
                        ((state == StData) || ((state == StIdle) && is_start));
    assign error_sent = (state == StData) && empty;

    always_ff @(posedge xgmii_tx_clk) begin
        if (sys_rst) begin
            tx_frames    <= 32'd0;
            tx_underruns <= 16'd0;
        end else begin
            if (frame_sent) begin
                tx_frames <= tx_frames + 32'd1;
            end
            if (error_sent) begin
                tx_underruns <= tx_underruns + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo72toxgmii.sv
// Drives two transmitters (Gap 2 and Gap 0) from bench FIFOs and checks them against a frame-level model.
module tb_fifo72toxgmii;
    import xgmii_pkg::*;

    localparam logic [71:0] JUNK = 72'h03_000000000000FDFB;
    localparam logic [71:0] W0   = 72'h01_01020304050607FB;
    localparam logic [71:0] W1   = 72'h00_DEADBEEFCAFEF00D;
    localparam logic [71:0] W2   = 72'hE0_0707FD0A0B0C0D0E;
    localparam logic [71:0] A2   = 72'h00_5555AAAA5555AAAA;
    localparam logic [71:0] SD   = 72'h00_0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        hold;
    logic [71:0] dout0, dout1;
    logic        empty0, empty1;
    logic        rd_en0, rd_en1, rd_clk0, rd_clk1;
    logic [71:0] txd0, txd1;
`ifdef FIFO72TOXGMII_STATS_EN
    logic [31:0] fr0, fr1;
    logic [15:0] un0, un1;
    int          exp_frames[2];
    int          exp_unders[2];
`endif

    logic [71:0] fq0[$];
    logic [71:0] fq1[$];
    logic [71:0] hist0[$];
    logic [71:0] hist1[$];

    int vectors = 0;
    int errors  = 0;

    // Model state: idles emitted since the last frame end, plus frame/abort flags.
    int idle_cnt[2];
    bit in_frame[2];
    bit draining[2];

    always #5 clk = ~clk;

    fifo72toxgmii #(.Gap(4'h2)) dut0 (
        .sys_rst      (sys_rst),
        .xgmii_tx_clk (clk),
        .dout         (dout0),
        .empty        (empty0),
        .rd_en        (rd_en0),
        .rd_clk       (rd_clk0),
        .xgmii_txd    (txd0)
`ifdef FIFO72TOXGMII_STATS_EN
        ,
        .tx_frames    (fr0),
        .tx_underruns (un0)
`endif
    );

    fifo72toxgmii #(.Gap(4'h0)) dut1 (
        .sys_rst      (sys_rst),
        .xgmii_tx_clk (clk),
        .dout         (dout1),
        .empty        (empty1),
        .rd_en        (rd_en1),
        .rd_clk       (rd_clk1),
        .xgmii_txd    (txd1)
`ifdef FIFO72TOXGMII_STATS_EN
        ,
        .tx_frames    (fr1),
        .tx_underruns (un1)
`endif
    );

    function automatic bit is_start_w(input logic [71:0] w);
        return w[64] && (w[7:0] == START);
    endfunction

    function automatic bit is_term_w(input logic [71:0] w);
        for (int l = 0; l < 8; l++) begin
            if (w[64+l] && (w[8*l +: 8] == TERM)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check72(input string name, input logic [71:0] got, input logic [71:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic refresh();
        empty0 = hold || (fq0.size() == 0);
        empty1 = hold || (fq1.size() == 0);
        dout0  = empty0 ? JUNK : fq0[0];
        dout1  = empty1 ? JUNK : fq1[0];
    endtask

    task automatic push_both(input logic [71:0] w);
        fq0.push_back(w);
        fq1.push_back(w);
    endtask

    task automatic push_frame(input int len, input int lane);
        logic [71:0] w;
        for (int i = 0; i < len; i++) begin
            w = {8'h00, $urandom, $urandom};
            if (i == 0) begin
                w[64]  = 1'b1;
                w[7:0] = START;
            end
            if (i == len - 1) begin
                for (int l = lane; l < 8; l++) begin
                    w[64+l]     = 1'b1;
                    w[8*l +: 8] = (l == lane) ? TERM : IDLE;
                end
            end
            push_both(w);
        end
    endtask

    task automatic model_reset(input int d, input int gap);
        in_frame[d] = 1'b0;
        draining[d] = 1'b0;
        idle_cnt[d] = gap;
`ifdef FIFO72TOXGMII_STATS_EN
        exp_frames[d] = 0;
        exp_unders[d] = 0;
`endif
    endtask

    task automatic model_step(input int d, input int gap, input bit emp,
                              input logic [71:0] head, output bit pop, output logic [71:0] o);
        bit sent;
        pop  = 1'b0;
        o    = IDLE_WORD;
        sent = 1'b0;
        if (draining[d]) begin
            if (!emp) begin
                if (is_start_w(head)) begin
                    draining[d] = 1'b0;
                    idle_cnt[d] = 0;
                end else begin
                    pop = 1'b1;
                    if (is_term_w(head)) begin
                        draining[d] = 1'b0;
                        idle_cnt[d] = 0;
                    end
                end
            end
        end else if (in_frame[d]) begin
            if (emp) begin
                o           = ERROR_WORD;
                in_frame[d] = 1'b0;
                draining[d] = 1'b1;
`ifdef FIFO72TOXGMII_STATS_EN
                exp_unders[d]++;
`endif
            end else begin
                pop = 1'b1;
                o   = head;
                if (is_term_w(head)) begin
                    in_frame[d] = 1'b0;
                    idle_cnt[d] = 0;
`ifdef FIFO72TOXGMII_STATS_EN
                    exp_frames[d]++;
`endif
                end
            end
        end else if (idle_cnt[d] < gap) begin
            idle_cnt[d]++;
        end else begin
            if (!emp) begin
                pop = 1'b1;
                if (is_start_w(head)) begin
                    sent = 1'b1;
                    o    = head;
                    if (is_term_w(head)) begin
                        idle_cnt[d] = 0;
`ifdef FIFO72TOXGMII_STATS_EN
                        exp_frames[d]++;
`endif
                    end else begin
                        in_frame[d] = 1'b1;
                    end
                end
            end
            if (!sent && idle_cnt[d] < 16) idle_cnt[d]++;
        end
    endtask

    // One clock: apply inputs, predict, compare rd_en before the edge and txd after it.
    task automatic step(input bit rst);
        bit          p0, p1, r0, r1;
        logic [71:0] o0, o1;
        @(negedge clk);
        sys_rst = rst;
        refresh();
        #1;
        if (rst) begin
            model_reset(0, 2);
            model_reset(1, 0);
            o0 = IDLE_WORD;
            o1 = IDLE_WORD;
        end else begin
            model_step(0, 2, empty0, dout0, p0, o0);
            model_step(1, 0, empty1, dout1, p1, o1);
            check_int("rd_en0", int'(rd_en0), int'(p0));
            check_int("rd_en1", int'(rd_en1), int'(p1));
        end
        r0 = rd_en0 && !empty0;
        r1 = rd_en1 && !empty1;
        @(posedge clk);
        #1;
        if (r0) void'(fq0.pop_front());
        if (r1) void'(fq1.pop_front());
        check72("txd0", txd0, o0);
        check72("txd1", txd1, o1);
`ifdef FIFO72TOXGMII_STATS_EN
        check_int("tx_frames0", int'(fr0), int'(32'(exp_frames[0])));
        check_int("tx_underruns1", int'(un1), int'(16'(exp_unders[1])));
`endif
        hist0.push_back(txd0);
        hist1.push_back(txd1);
        refresh();
    endtask

    task automatic clear_hist();
        hist0.delete();
        hist1.delete();
    endtask

    initial begin
        int r;
        sys_rst = 1'b1;
        hold    = 1'b1;
        model_reset(0, 2);
        model_reset(1, 0);
        refresh();
        step(1);
        step(1);

        // Reset with a 3-word frame queued, terminate in lane 5.
        push_both(W0); push_both(W1); push_both(W2);
        clear_hist();
        step(1);
        hold = 1'b0;
        for (int i = 0; i < 6; i++) step(0);
        check72("rst_idle", hist0[0], IDLE_WORD);
        check72("f1_w0", hist0[1], W0);
        check72("f1_w1", hist0[2], W1);
        check72("f1_w2", hist0[3], W2);
        check72("f1_gap0", hist0[4], IDLE_WORD);
        check72("f1_gap1", hist0[5], IDLE_WORD);

        // Back-to-back frames.
        clear_hist();
        push_both(W0); push_both(W1); push_both(W2);
        push_both(W0); push_both(W1); push_both(W2);
        for (int i = 0; i < 10; i++) step(0);
        check72("b2b_gap_a", hist0[3], IDLE_WORD);
        check72("b2b_gap_b", hist0[4], IDLE_WORD);
        check72("b2b_start", hist0[5], W0);
        check72("b2b_gap0_start", hist1[3], W0);

        // Underrun after two words, rest of the frame arrives later.
        clear_hist();
        push_both(W0); push_both(W1);
        step(0); step(0); step(0);
        push_both(A2); push_both(W2);
        push_both(W0); push_both(W1); push_both(W2);
        for (int i = 0; i < 12; i++) step(0);
        check72("urun_err0", hist0[2], ERROR_WORD);
        check72("urun_idle0", hist0[3], IDLE_WORD);
        check72("urun_idle6", hist0[6], IDLE_WORD);
        check72("urun_next0", hist0[7], W0);
        check72("urun_err1", hist1[2], ERROR_WORD);
        check72("urun_next1", hist1[5], W0);

        // Idles and stray data ahead of a start.
        clear_hist();
        push_both(IDLE_WORD); push_both(SD); push_both(IDLE_WORD);
        push_both(W0); push_both(W1); push_both(W2);
        for (int i = 0; i < 9; i++) step(0);
        check72("junk_idle", hist0[2], IDLE_WORD);
        check72("junk_start", hist0[3], W0);
        check72("junk_term", hist0[5], W2);
        check_int("junk_fifo_empty", fq0.size(), 0);

        // Reset mid-frame.
        clear_hist();
        push_both(W0); push_both(W1); push_both(W2);
        push_both(W0); push_both(W1); push_both(W2);
        step(0);
        hold = 1'b1;
        step(1);
        hold = 1'b0;
        for (int i = 0; i < 8; i++) step(0);
        check72("mrst_idle", hist0[1], IDLE_WORD);
        check72("mrst_discard", hist0[2], IDLE_WORD);
        check72("mrst_start", hist0[4], W0);
        check72("mrst_term", hist0[6], W2);
        check72("mrst_start1", hist1[4], W0);

        // Randomized traffic with stalls and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            hold = ($urandom_range(0, 9) == 0);
            if (fq1.size() < 6) begin
                r = $urandom_range(0, 7);
                if (r == 0) push_both(IDLE_WORD);
                else if (r == 1) push_both({8'h00, $urandom, $urandom});
                else begin
                    r = $urandom_range(1, 6);
                    push_frame(r, (r == 1) ? $urandom_range(1, 7) : $urandom_range(0, 7));
                end
            end
            step($urandom_range(0, 399) == 0);
        end
        hold = 1'b0;
        for (int i = 0; i < 200; i++) step(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
